flat_buffer_capture_ctrl: RTL and testbench
===========================================

// Module: flat_buffer_capture_ctrl
// PURPOSE
//  Sequences capture/readout of the flattened sample-history window (numChannels*depth entries of bitwidth).
//  On a trigger it waits a programmable holdoff, freezes the history buffer via shift_en,
//  streams every entry out over a narrow valid/ready port (index 0 first), then releases the buffer.
//  Sits between the flat history buffer and the debug/JTAG readout path.
// PARAMETERS
//  numChannels  16  channels per history slot
//  bitwidth     8   bits per entry
//  depth        5   history slots per channel
//  holdWidth    16  width of holdoff count
// PORTS
//  clk            in   1                         system clock, all state on rising edge
//  rst            in   1                         async active-high reset
//  trig           in   1                         capture request, sampled each cycle
//  holdoff        in   holdWidth                 cycles between trig and freeze, sampled with trig
//  abort          in   1                         cancel capture/readout
//  clr_flags      in   1                         clears trig_dropped
//  flat_in        in   [N-1:0][bitwidth-1:0]     flattened buffer contents, N=numChannels*depth
//  shift_en       out  1                         1 = buffer free-running, 0 = frozen
//  out_data       out  bitwidth                  flat_in[out_idx]
//  out_idx        out  $clog2(N)                 index of current entry
//  out_valid      out  1                         out_data/out_idx valid
//  out_ready      in   1                         sink accepts when out_valid&out_ready
//  out_last       out  1                         out_valid & out_idx==N-1
//  busy           out  1                         state != IDLE
//  done           out  1                         1-cycle pulse after final transfer
//  aborted        out  1                         1-cycle pulse when abort takes effect
//  trig_dropped   out  1                         sticky: trig seen while busy
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, shift_en=1, out_valid=0, out_idx=0, done=0, aborted=0, trig_dropped=0.
//  States: IDLE, HOLDOFF, FREEZE, STREAM, DONE (enum in package).
//  IDLE: trig&holdoff!=0 -> HOLDOFF, cnt<=holdoff-1; trig&holdoff==0 -> FREEZE.
//  HOLDOFF: cnt decrements each cycle; at cnt==0 -> FREEZE. holdoff=H gives exactly H cycles in HOLDOFF.
//  FREEZE: shift_en registered low from entry; exactly 1 cycle (buffer settle), out_idx<=0 -> STREAM.
//  STREAM: out_valid=1, shift_en=0; out_data = flat_in[out_idx] (comb mux, input frozen).
//   Transfer on out_valid&out_ready: out_idx++; transfer at idx N-1 -> DONE. out_valid held, data stable while !out_ready.
//  DONE: done=1 one cycle, shift_en<=1, out_idx<=0 -> IDLE. trig in DONE is dropped (flagged).
//  Latency: trig at cycle t, holdoff=0 -> shift_en low at t+1, first out_valid at t+2.
//  abort: highest priority; in any non-IDLE state -> IDLE next cycle, out_valid=0, shift_en=1,
//   aborted pulses, no done. abort in IDLE: ignored, no pulse. abort with trig same cycle: no capture.
//  trig_dropped: set when trig & state!=IDLE & !abort; cleared by clr_flags; set wins if both same cycle.
//  out_idx never wraps past N-1; no counter overflow since holdoff loaded, not accumulated.
// STRUCTURE
//  Package flat_buffer_ctrl_pkg: typedef enum logic [2:0] cap_state_t; localparam function for idx width.
//  One sub-module natural: flat_buffer_mux (N:1 entry select, parameterised numChannels/depth/bitwidth).
//  FSM, holdoff counter, index counter, flags in this module.
// TESTING
//  trig, holdoff=0, out_ready=1 -> shift_en low 1 cycle after trig; 80 transfers idx 0..79; out_last at 79; done pulse; shift_en=1.
//  trig, holdoff=3 -> exactly 3 HOLDOFF cycles then FREEZE; flat_in ramp k -> out_data==k for every idx.
//  out_ready random 50% -> out_data/out_idx stable while stalled; exactly 80 transfers, no dup/skip.
//  abort at idx 10 during STREAM -> next cycle out_valid=0, shift_en=1, aborted=1, done never pulses.
//  trig during STREAM -> trig_dropped=1, capture continues; clr_flags with simultaneous trig -> remains 1.
//  rst asserted mid-STREAM (async, off-edge) -> outputs reach reset values immediately; next trig works normally.

Source files
------------

// File: rtl/flat_buffer_ctrl_pkg.sv
// Shared types and sizing helpers for the flat history buffer capture controller.
package flat_buffer_ctrl_pkg;

    localparam int unsigned DEF_NUM_CHANNELS = 16;
    localparam int unsigned DEF_BITWIDTH     = 8;
    localparam int unsigned DEF_DEPTH        = 5;
    localparam int unsigned DEF_HOLD_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLDOFF = 3'd1,
        ST_FREEZE  = 3'd2,
        ST_STREAM  = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flat_buffer_mux.sv
// N:1 entry select over the flattened history buffer; unmatched index yields zero.
module flat_buffer_mux
    import flat_buffer_ctrl_pkg::*;
#(
    parameter int unsigned numChannels = DEF_NUM_CHANNELS,
    parameter int unsigned bitwidth    = DEF_BITWIDTH,
    parameter int unsigned depth       = DEF_DEPTH
) (
    input  logic [numChannels*depth-1:0][bitwidth-1:0]  flat_in,
    input  logic [idx_width(numChannels*depth)-1:0]     sel,
    output logic [bitwidth-1:0]                         data
);

    localparam int unsigned N  = numChannels * depth;
    localparam int unsigned IW = idx_width(N);

    always_comb begin
        data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                data = flat_in[i];
            end
        end
    end

endmodule

// File: rtl/flat_buffer_capture_ctrl.sv
// Capture/readout sequencer: trigger, holdoff, freeze the history buffer,
// stream every entry over a valid/ready port, then release the buffer.
module flat_buffer_capture_ctrl
    import flat_buffer_ctrl_pkg::*;
#(
    parameter int unsigned numChannels = DEF_NUM_CHANNELS,
    parameter int unsigned bitwidth    = DEF_BITWIDTH,
    parameter int unsigned depth       = DEF_DEPTH,
    parameter int unsigned holdWidth   = DEF_HOLD_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        trig,
    input  logic [holdWidth-1:0]                        holdoff,
    input  logic                                        abort,
    input  logic                                        clr_flags,
    input  logic [numChannels*depth-1:0][bitwidth-1:0]  flat_in,
    output logic                                        shift_en,
    output logic [bitwidth-1:0]                         out_data,
    output logic [idx_width(numChannels*depth)-1:0]     out_idx,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        aborted,
    output logic                                        trig_dropped
);

    localparam int unsigned N  = numChannels * depth;
    localparam int unsigned IW = idx_width(N);

    cap_state_t           state;
    logic [holdWidth-1:0] cnt;

    // Sequencer: abort overrides everything except reset; done/aborted are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            out_idx      <= '0;
            shift_en     <= 1'b1;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            trig_dropped <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if (trig && (state != ST_IDLE) && !abort) begin
                trig_dropped <= 1'b1;
            end else if (clr_flags) begin
                trig_dropped <= 1'b0;
            end

            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                out_idx   <= '0;
                shift_en  <= 1'b1;
                out_valid <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig && !abort) begin
                            if (holdoff != '0) begin
                                state <= ST_HOLDOFF;
                                cnt   <= holdoff - holdWidth'(1);
                            end else begin
                                state    <= ST_FREEZE;
                                shift_en <= 1'b0;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt == '0) begin
                            state    <= ST_FREEZE;
                            shift_en <= 1'b0;
                        end else begin
                            cnt <= cnt - holdWidth'(1);
                        end
                    end
                    // One settle cycle with the buffer frozen before the first entry is offered.
                    ST_FREEZE: begin
                        state     <= ST_STREAM;
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                    end
                    ST_STREAM: begin
                        if (out_ready) begin
                            if (out_idx == IW'(N - 1)) begin
                                state     <= ST_DONE;
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                out_idx <= out_idx + IW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        shift_en <= 1'b1;
                        out_idx  <= '0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        shift_en  <= 1'b1;
                        out_valid <= 1'b0;
                        out_idx   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign out_last = out_valid && (out_idx == IW'(N - 1));

    flat_buffer_mux #(
        .numChannels (numChannels),
        .bitwidth    (bitwidth),
        .depth       (depth)
    ) u_mux (
        .flat_in (flat_in),
        .sel     (out_idx),
        .data    (out_data)
    );

endmodule

// File: tb/tb_flat_buffer_capture_ctrl.sv
// Bench for flat_buffer_capture_ctrl: vector table, directed corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_flat_buffer_capture_ctrl;

    localparam int unsigned NCH = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned DEP = 5;
    localparam int unsigned HW  = 16;
    localparam int unsigned N   = NCH * DEP;
    localparam int unsigned IW  = 7;
    localparam int unsigned NV  = 15;

    logic                      clk;
    logic                      rst;
    logic                      trig;
    logic [HW-1:0]             holdoff;
    logic                      abort;
    logic                      clr_flags;
    logic [N-1:0][BW-1:0]      flat_in;
    logic                      shift_en;
    logic [BW-1:0]             out_data;
    logic [IW-1:0]             out_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic                      busy;
    logic                      done;
    logic                      aborted;
    logic                      trig_dropped;

    int checks = 0;
    int errors = 0;

    flat_buffer_capture_ctrl #(
        .numChannels (NCH),
        .bitwidth    (BW),
        .depth       (DEP),
        .holdWidth   (HW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .holdoff      (holdoff),
        .abort        (abort),
        .clr_flags    (clr_flags),
        .flat_in      (flat_in),
        .shift_en     (shift_en),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .trig_dropped (trig_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          trig;
        logic [HW-1:0] holdoff;
        logic          abort;
        logic          clr;
        logic          ready;
        logic          e_shift;
        logic          e_valid;
        logic [IW-1:0] e_idx;
        logic          e_busy;
        logic          e_done;
        logic          e_aborted;
        logic          e_dropped;
    } vec_t;

    vec_t vecs [NV];

    task automatic cmp(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic sh, input logic v,
                              input logic [IW-1:0] idx, input logic bz, input logic dn,
                              input logic ab, input logic dr);
        logic [BW-1:0] exp_data;
        cmp({tag, ".shift_en"},     int'(shift_en),     int'(sh));
        cmp({tag, ".out_valid"},    int'(out_valid),    int'(v));
        cmp({tag, ".out_idx"},      int'(out_idx),      int'(idx));
        cmp({tag, ".busy"},         int'(busy),         int'(bz));
        cmp({tag, ".done"},         int'(done),         int'(dn));
        cmp({tag, ".aborted"},      int'(aborted),      int'(ab));
        cmp({tag, ".trig_dropped"}, int'(trig_dropped), int'(dr));
        cmp({tag, ".out_last"},     int'(out_last),     int'(v && (int'(idx) == int'(N) - 1)));
        if (v) begin
            exp_data = flat_in[idx];
            cmp({tag, ".out_data"}, int'(out_data), int'(exp_data));
        end
    endtask

    task automatic clear_inputs();
        trig      = 1'b0;
        holdoff   = '0;
        abort     = 1'b0;
        clr_flags = 1'b0;
    endtask

    // Full capture with out_ready held high over a ramp pattern; starts from idle.
    task automatic full_capture(input logic [HW-1:0] h, input string tag);
        int n;
        int hcnt;
        int fcnt;
        for (int k = 0; k < int'(N); k++) flat_in[k] = BW'(k);
        out_ready = 1'b1;
        trig      = 1'b1;
        holdoff   = h;
        step();
        clear_inputs();
        n = 0; hcnt = 0; fcnt = 0;
        while (!out_valid && n < 50) begin
            if (busy && shift_en)  hcnt++;
            if (busy && !shift_en) fcnt++;
            step();
            n++;
        end
        cmp({tag, ".reached_stream"}, int'(out_valid), 1);
        cmp({tag, ".holdoff_cycles"}, hcnt, int'(h));
        cmp({tag, ".freeze_cycles"},  fcnt, 1);
        for (int k = 0; k < int'(N); k++) begin
            cmp($sformatf("%s.valid[%0d]", tag, k), int'(out_valid), 1);
            cmp($sformatf("%s.idx[%0d]",   tag, k), int'(out_idx),   k);
            cmp($sformatf("%s.data[%0d]",  tag, k), int'(out_data),  k);
            cmp($sformatf("%s.last[%0d]",  tag, k), int'(out_last),  int'(k == int'(N) - 1));
            cmp($sformatf("%s.shift[%0d]", tag, k), int'(shift_en),  0);
            step();
        end
        cmp({tag, ".done_pulse"},     int'(done),      1);
        cmp({tag, ".valid_after"},    int'(out_valid), 0);
        cmp({tag, ".shift_in_done"},  int'(shift_en),  0);
        step();
        cmp({tag, ".done_cleared"},   int'(done),      0);
        cmp({tag, ".shift_released"}, int'(shift_en),  1);
        cmp({tag, ".idle"},           int'(busy),      0);
    endtask

    // Reference model: a capture is described by when the freeze begins and how
    // many entries have been accepted; everything else follows arithmetically.
    bit m_busy;
    int m_freeze_at;
    int m_xfers;
    bit m_aborted;
    bit m_dropped;
    int cyc;

    logic          e_sh, e_v, e_bz, e_dn;
    logic [IW-1:0] e_idx;

    task automatic model_expect();
        e_sh = 1'b1; e_v = 1'b0; e_idx = '0; e_bz = 1'b0; e_dn = 1'b0;
        if (m_busy) begin
            e_bz = 1'b1;
            if (cyc == m_freeze_at) begin
                e_sh = 1'b0;
            end else if (cyc > m_freeze_at) begin
                e_sh = 1'b0;
                if (m_xfers < int'(N)) begin
                    e_v   = 1'b1;
                    e_idx = IW'(m_xfers);
                end else begin
                    e_idx = IW'(N - 1);
                    e_dn  = 1'b1;
                end
            end
        end
    endtask

    task automatic model_advance();
        bit streaming;
        bit in_done;
        streaming = m_busy && (cyc > m_freeze_at) && (m_xfers < int'(N));
        in_done   = m_busy && (cyc > m_freeze_at) && (m_xfers == int'(N));
        if (trig && m_busy && !abort) m_dropped = 1'b1;
        else if (clr_flags)           m_dropped = 1'b0;
        m_aborted = m_busy && abort;
        if (m_busy && abort) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (in_done)                m_busy = 1'b0;
            else if (streaming && out_ready) m_xfers++;
        end else if (trig && !abort) begin
            m_busy      = 1'b1;
            m_freeze_at = cyc + 1 + int'(holdoff);
            m_xfers     = 0;
        end
        cyc++;
    endtask

    initial begin
        int n;
        int dcnt;

        rst = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        for (int k = 0; k < int'(N); k++) flat_in[k] = BW'($urandom);
        #3;
        check_outs("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_outs("post_reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        //         trig  holdoff abort clr  rdy   sh    v     idx   busy  done  ab    dr
        vecs[0]  = '{1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < int'(NV); i++) begin
            trig      = vecs[i].trig;
            holdoff   = vecs[i].holdoff;
            abort     = vecs[i].abort;
            clr_flags = vecs[i].clr;
            out_ready = vecs[i].ready;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_shift, vecs[i].e_valid, vecs[i].e_idx,
                       vecs[i].e_busy, vecs[i].e_done, vecs[i].e_aborted, vecs[i].e_dropped);
        end
        clear_inputs();
        out_ready = 1'b0;
        step();

        full_capture(16'd0, "cap_h0");
        full_capture(16'd3, "cap_h3");

        // Abort once entry 10 is on the port.
        out_ready = 1'b1;
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == IW'(10)) && n < 50) begin
            step();
            n++;
        end
        cmp("abort.reached_idx10", int'(out_idx), 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmp("abort.valid",   int'(out_valid), 0);
        cmp("abort.shift",   int'(shift_en),  1);
        cmp("abort.pulse",   int'(aborted),   1);
        cmp("abort.idle",    int'(busy),      0);
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) dcnt++;
        end
        cmp("abort.no_done", dcnt, 0);
        cmp("abort.pulse_cleared", int'(aborted), 0);

        // Asynchronous reset in the middle of streaming, away from any clock edge.
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == IW'(20)) && n < 50) begin
            step();
            n++;
        end
        cmp("rst_mid.reached_idx20", int'(out_idx), 20);
        #2;
        rst = 1'b1;
        #1;
        check_outs("rst_mid", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        full_capture(16'd0, "cap_after_rst");

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_aborted = 1'b0; m_dropped = 1'b0;
        m_freeze_at = 0; m_xfers = 0; cyc = 0;
        for (int c = 0; c < 6000; c++) begin
            model_expect();
            check_outs("rand", e_sh, e_v, e_idx, e_bz, e_dn, m_aborted, m_dropped);
            trig      = ($urandom_range(0, 19) == 0);
            holdoff   = HW'($urandom_range(0, 4));
            abort     = ($urandom_range(0, 299) == 0);
            clr_flags = ($urandom_range(0, 31) == 0);
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                for (int k = 0; k < int'(N); k++) flat_in[k] = BW'($urandom);
            end
            model_advance();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
